running_max_array: RTL and testbench
====================================

RUNNING_MAX_ARRAY -- requirements
Module: running_max_array

Interface
REQ-001 Parameter LANES, default 4: number of independent query-row lanes processed in parallel.
REQ-002 Parameter DATA_W, default 16: signed two's-complement score width per lane.
REQ-003 Parameter V_W, default 128: width of the pass-through V payload.
REQ-004 Parameter MAX_SEQ, default 64: maximum key count per row; counter width CW = clog2(MAX_SEQ+1).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 vld_in  input  1  upstream beat valid.
REQ-008 rdy_out  output  1  block can accept a beat.
REQ-009 vld_out  output  1  output beat valid.
REQ-010 rdy_in  input  1  downstream accepts the output beat.
REQ-011 seq_len  input  CW  keys per row; sampled only on the first beat of a row.
REQ-012 s_in  input  LANES*DATA_W  per-lane scores, lane 0 in the LSBs.
REQ-013 v_in  input  V_W  V vector accompanying the beat.
REQ-014 s_out, m_prev_out, m_out  output  LANES*DATA_W each  score, max before the beat, max after the beat.
REQ-015 v_out  output  V_W  registered V payload.
REQ-016 first_out, last_out  output  1 each  beat is the first / last key of its row.

Function
REQ-017 A beat SHALL be accepted on a cycle with vld_in=1 and rdy_out=1, and appears on the outputs the following cycle (latency 1).
REQ-018 The internal running max m[l] per lane SHALL persist across beats; no external m_prev feedback exists.
REQ-019 On the first beat of a row, the effective m_prev SHALL be the most negative DATA_W value (-2^(DATA_W-1)), not 0.
REQ-020 m_out[l] SHALL equal the signed max of s[l] and effective m_prev[l]; on a tie it SHALL equal m_prev[l].
REQ-021 The key counter SHALL start at 0, increment per accepted beat, and wrap to 0 after the beat with counter = row_len-1.
REQ-022 row_len SHALL be latched from seq_len when counter=0; seq_len=0 or seq_len>MAX_SEQ SHALL be treated as MAX_SEQ.
REQ-023 With row_len=1 every beat SHALL assert both first_out and last_out.
REQ-024 When no beat is accepted and rdy_in=1, vld_out SHALL drop to 0; when rdy_in=0, all outputs SHALL hold unchanged.
REQ-025 Simultaneous accept and drain SHALL load the new beat; no beat SHALL be lost or duplicated.

Reset
REQ-026 Reset SHALL clear vld_out, first_out, last_out, counter, row_len, s_out, m_out, m_prev_out, v_out, and every lane's m, all to 0.
REQ-027 Reset asserted mid-row SHALL discard the partial row; the next accepted beat is the first of a new row.
REQ-028 rdy_out SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-029 Macro RUNNING_MAX_SKID_EN: when defined, a one-entry skid buffer SHALL be added and rdy_out SHALL be driven from a register (!skid_full); no combinational rdy_in-to-rdy_out path shall exist.
REQ-030 When RUNNING_MAX_SKID_EN is defined, one beat accepted while the output stalls SHALL be held in the skid buffer and issued in order.
REQ-031 When RUNNING_MAX_SKID_EN is not defined, rdy_out SHALL equal rdy_in OR NOT vld_out (combinational).

Verification
REQ-032 Scenario: LANES=4, seq_len=3, lane 0 scores 5, -2, 9 -> m_out 5, 5, 9; m_prev_out -32768, 5, 5; first_out on beat 0; last_out on beat 2.
REQ-033 Scenario: all scores -100 on the first beat -> m_out=-100 (proves the negative initial value), m_prev_out=-32768.
REQ-034 Scenario: two back-to-back rows with seq_len=2, scores 7, 3 then 1, 0 -> second row m_out 1, 1 (no carry-over from row 1).
REQ-035 Scenario: rdy_in=0 for 5 cycles with vld_in=1 -> outputs frozen; skid build accepts exactly 1 extra beat, non-skid build accepts 0; in-order release afterward.
REQ-036 Scenario: reset asserted after beat 1 of a seq_len=4 row -> all outputs 0; the next beat has first_out=1 and m_prev_out=-32768.
REQ-037 Scenario: seq_len=0 with MAX_SEQ=64 -> last_out asserts on beat 63 only.

Source files
------------

// File: rtl/running_max_array_if.sv
// Handshake and data bundle for running_max_array: upstream beat in, registered
// score/max/V beat out.
interface running_max_array_if #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 16,
    parameter int V_W     = 128,
    parameter int MAX_SEQ = 64
);
    localparam int CW = $clog2(MAX_SEQ + 1);

    logic                    vld_in;
    logic                    rdy_out;
    logic                    vld_out;
    logic                    rdy_in;
    logic [CW-1:0]           seq_len;
    logic [LANES*DATA_W-1:0] s_in;
    logic [V_W-1:0]          v_in;
    logic [LANES*DATA_W-1:0] s_out;
    logic [LANES*DATA_W-1:0] m_prev_out;
    logic [LANES*DATA_W-1:0] m_out;
    logic [V_W-1:0]          v_out;
    logic                    first_out;
    logic                    last_out;

    modport master (
        output vld_in, rdy_in, seq_len, s_in, v_in,
        input  rdy_out, vld_out, s_out, m_prev_out, m_out, v_out, first_out, last_out
    );

    modport slave (
        input  vld_in, rdy_in, seq_len, s_in, v_in,
        output rdy_out, vld_out, s_out, m_prev_out, m_out, v_out, first_out, last_out
    );
endinterface

// File: rtl/running_max_array.sv
// Per-lane running signed maximum over the keys of a row, one beat of latency.
// Define RUNNING_MAX_SKID_EN to add a one-entry skid buffer and a registered rdy_out.
module running_max_array #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 16,
    parameter int V_W     = 128,
    parameter int MAX_SEQ = 64,
    localparam int CW     = $clog2(MAX_SEQ + 1)
) (
    input  logic              clock,
    input  logic              reset,
    running_max_array_if.slave bus
);
    localparam logic [CW-1:0]            MAX_LEN = CW'(MAX_SEQ);
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           row_len_q;
    logic [LANES*DATA_W-1:0] m_q;

    logic                    out_free;
    logic                    accept;
    logic                    load;
    logic [CW-1:0]           src_seq_len;
    logic [LANES*DATA_W-1:0] src_s;
    logic [V_W-1:0]          src_v;

    logic                    first;
    logic                    last;
    logic [CW-1:0]           row_len_eff;
    logic [LANES*DATA_W-1:0] m_prev_next;
    logic [LANES*DATA_W-1:0] m_next;

    assign out_free = ~bus.vld_out | bus.rdy_in;

`ifdef RUNNING_MAX_SKID_EN
    logic                    skid_full;
    logic [CW-1:0]           skid_seq_len;
    logic [LANES*DATA_W-1:0] skid_s;
    logic [V_W-1:0]          skid_v;

    // Raw beats are parked in the skid; the max/counter state advances only when
    // a beat enters the output stage, which keeps row order intact.
    assign bus.rdy_out = ~skid_full;
    assign accept      = bus.vld_in & ~skid_full;
    assign load        = out_free & (skid_full | accept);
    assign src_seq_len = skid_full ? skid_seq_len : bus.seq_len;
    assign src_s       = skid_full ? skid_s       : bus.s_in;
    assign src_v       = skid_full ? skid_v       : bus.v_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            skid_full    <= 1'b0;
            skid_seq_len <= '0;
            skid_s       <= '0;
            skid_v       <= '0;
        end else if (skid_full && out_free) begin
            skid_full <= 1'b0;
        end else if (accept && !out_free) begin
            skid_full    <= 1'b1;
            skid_seq_len <= bus.seq_len;
            skid_s       <= bus.s_in;
            skid_v       <= bus.v_in;
        end
    end
`else
    assign bus.rdy_out = out_free;
    assign accept      = bus.vld_in & out_free;
    assign load        = accept;
    assign src_seq_len = bus.seq_len;
    assign src_s       = bus.s_in;
    assign src_v       = bus.v_in;
`endif

    always_comb begin : datapath
        logic signed [DATA_W-1:0] s_l;
        logic signed [DATA_W-1:0] mp_l;
        s_l         = '0;
        mp_l        = '0;
        m_prev_next = '0;
        m_next      = '0;
        first       = (cnt_q == '0);
        row_len_eff = row_len_q;
        if (first) begin
            row_len_eff = (src_seq_len == '0 || src_seq_len > MAX_LEN) ? MAX_LEN : src_seq_len;
        end
        last = (cnt_q == row_len_eff - CW'(1));
        for (int l = 0; l < LANES; l++) begin
            s_l  = src_s[l*DATA_W +: DATA_W];
            mp_l = first ? MIN_VAL : m_q[l*DATA_W +: DATA_W];
            m_prev_next[l*DATA_W +: DATA_W] = mp_l;
            // Strict compare so a tie keeps the previous max.
            m_next[l*DATA_W +: DATA_W] = (s_l > mp_l) ? s_l : mp_l;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vld_out    <= 1'b0;
            bus.first_out  <= 1'b0;
            bus.last_out   <= 1'b0;
            bus.s_out      <= '0;
            bus.m_prev_out <= '0;
            bus.m_out      <= '0;
            bus.v_out      <= '0;
            m_q            <= '0;
            cnt_q          <= '0;
            row_len_q      <= '0;
        end else if (load) begin
            bus.vld_out    <= 1'b1;
            bus.first_out  <= first;
            bus.last_out   <= last;
            bus.s_out      <= src_s;
            bus.m_prev_out <= m_prev_next;
            bus.m_out      <= m_next;
            bus.v_out      <= src_v;
            m_q            <= m_next;
            row_len_q      <= row_len_eff;
            cnt_q          <= last ? '0 : cnt_q + CW'(1);
        end else if (bus.rdy_in) begin
            bus.vld_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_running_max_array.sv
// Directed self-checking bench for running_max_array (both skid and non-skid builds).
module tb_running_max_array;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

`ifdef RUNNING_MAX_SKID_EN
    localparam int EXP_EXTRA = 1;
`else
    localparam int EXP_EXTRA = 0;
`endif

    running_max_array_if #(.LANES(4), .DATA_W(16), .V_W(128), .MAX_SEQ(64)) bus ();

    running_max_array #(.LANES(4), .DATA_W(16), .V_W(128), .MAX_SEQ(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic int lane(input logic [63:0] v, input int l);
        logic signed [15:0] x;
        x = v[l*16 +: 16];
        return int'(x);
    endfunction

    task automatic beat(input int seq, input logic [63:0] s, input logic [127:0] v);
        bus.vld_in  = 1'b1;
        bus.rdy_in  = 1'b1;
        bus.seq_len = 7'(seq);
        bus.s_in    = s;
        bus.v_in    = v;
        @(posedge clock);
        @(negedge clock);
        bus.vld_in = 1'b0;
    endtask

    task automatic idle;
        bus.vld_in = 1'b0;
        bus.rdy_in = 1'b1;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.vld_out); end
        checks++; if ({bus.first_out, bus.last_out} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.first_out, bus.last_out}); end
        checks++; if (bus.s_out !== 64'd0 || bus.m_out !== 64'd0 || bus.m_prev_out !== 64'd0) begin errors++; $display("FAIL reset_data: s=%h m=%h mp=%h want 0", bus.s_out, bus.m_out, bus.m_prev_out); end
        checks++; if (bus.v_out !== 128'd0) begin errors++; $display("FAIL reset_v: got %h want 0", bus.v_out); end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.rdy_out !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", bus.rdy_out); end
    endtask

    task automatic test_basic_row;
        beat(3, pack4(5, 0, 0, -1), 128'h11);
        checks++; if (bus.vld_out !== 1'b1 || bus.first_out !== 1'b1 || bus.last_out !== 1'b0) begin errors++; $display("FAIL basic_b0_flags: vld/first/last=%b%b%b want 110", bus.vld_out, bus.first_out, bus.last_out); end
        checks++; if (lane(bus.m_out, 0) !== 5 || lane(bus.m_prev_out, 0) !== -32768) begin errors++; $display("FAIL basic_b0_l0: m=%0d mp=%0d want 5 -32768", lane(bus.m_out, 0), lane(bus.m_prev_out, 0)); end
        checks++; if (lane(bus.m_out, 3) !== -1) begin errors++; $display("FAIL basic_b0_l3: m=%0d want -1", lane(bus.m_out, 3)); end
        beat(3, pack4(-2, 0, 0, 4), 128'h22);
        checks++; if (lane(bus.m_out, 0) !== 5 || lane(bus.m_prev_out, 0) !== 5 || lane(bus.s_out, 0) !== -2) begin errors++; $display("FAIL basic_b1_l0: m=%0d mp=%0d s=%0d want 5 5 -2", lane(bus.m_out, 0), lane(bus.m_prev_out, 0), lane(bus.s_out, 0)); end
        checks++; if (bus.first_out !== 1'b0 || bus.last_out !== 1'b0) begin errors++; $display("FAIL basic_b1_flags: first/last=%b%b want 00", bus.first_out, bus.last_out); end
        beat(3, pack4(9, 0, 0, 3), 128'h33);
        checks++; if (lane(bus.m_out, 0) !== 9 || lane(bus.m_prev_out, 0) !== 5) begin errors++; $display("FAIL basic_b2_l0: m=%0d mp=%0d want 9 5", lane(bus.m_out, 0), lane(bus.m_prev_out, 0)); end
        checks++; if (lane(bus.m_out, 3) !== 4 || lane(bus.m_prev_out, 3) !== 4) begin errors++; $display("FAIL basic_b2_l3: m=%0d mp=%0d want 4 4", lane(bus.m_out, 3), lane(bus.m_prev_out, 3)); end
        checks++; if (bus.last_out !== 1'b1 || bus.v_out !== 128'h33) begin errors++; $display("FAIL basic_b2_last_v: last=%b v=%h want 1 33", bus.last_out, bus.v_out); end
        idle();
        checks++; if (bus.vld_out !== 1'b0) begin errors++; $display("FAIL basic_drain: vld=%b want 0", bus.vld_out); end
    endtask

    task automatic test_negative_init;
        beat(1, pack4(-100, -100, -100, -100), 128'h0);
        checks++; if (lane(bus.m_out, 0) !== -100 || lane(bus.m_out, 2) !== -100) begin errors++; $display("FAIL neg_m: l0=%0d l2=%0d want -100", lane(bus.m_out, 0), lane(bus.m_out, 2)); end
        checks++; if (lane(bus.m_prev_out, 0) !== -32768) begin errors++; $display("FAIL neg_mp: got %0d want -32768", lane(bus.m_prev_out, 0)); end
        checks++; if (bus.first_out !== 1'b1 || bus.last_out !== 1'b1) begin errors++; $display("FAIL len1_a: first/last=%b%b want 11", bus.first_out, bus.last_out); end
        beat(1, pack4(50, 0, 0, 0), 128'h0);
        checks++; if (bus.first_out !== 1'b1 || bus.last_out !== 1'b1 || lane(bus.m_prev_out, 0) !== -32768 || lane(bus.m_out, 0) !== 50) begin errors++; $display("FAIL len1_b: first/last=%b%b mp=%0d m=%0d want 11 -32768 50", bus.first_out, bus.last_out, lane(bus.m_prev_out, 0), lane(bus.m_out, 0)); end
    endtask

    task automatic test_back_to_back;
        beat(2, pack4(7, 0, 0, 0), 128'h1);
        checks++; if (lane(bus.m_out, 0) !== 7) begin errors++; $display("FAIL b2b_r1b0: m=%0d want 7", lane(bus.m_out, 0)); end
        // seq_len changes on a non-first beat and must be ignored
        beat(5, pack4(3, 0, 0, 0), 128'h2);
        checks++; if (lane(bus.m_out, 0) !== 7 || bus.last_out !== 1'b1) begin errors++; $display("FAIL b2b_r1b1: m=%0d last=%b want 7 1", lane(bus.m_out, 0), bus.last_out); end
        beat(2, pack4(1, 0, 0, 0), 128'h3);
        checks++; if (lane(bus.m_out, 0) !== 1 || lane(bus.m_prev_out, 0) !== -32768 || bus.first_out !== 1'b1) begin errors++; $display("FAIL b2b_r2b0: m=%0d mp=%0d first=%b want 1 -32768 1", lane(bus.m_out, 0), lane(bus.m_prev_out, 0), bus.first_out); end
        beat(2, pack4(0, 0, 0, 0), 128'h4);
        checks++; if (lane(bus.m_out, 0) !== 1 || lane(bus.m_prev_out, 0) !== 1 || bus.last_out !== 1'b1) begin errors++; $display("FAIL b2b_r2b1: m=%0d mp=%0d last=%b want 1 1 1", lane(bus.m_out, 0), lane(bus.m_prev_out, 0), bus.last_out); end
    endtask

    task automatic test_stall;
        logic [63:0] bs [4];
        int exp_s [4];
        int exp_m [4];
        int exp_p [4];
        int idx;
        int oidx;
        int stall_acc;
        logic acc;
        bs    = '{pack4(10, 0, 0, 0), pack4(20, 0, 0, 0), pack4(30, 0, 0, 0), pack4(5, 0, 0, 0)};
        exp_s = '{10, 20, 30, 5};
        exp_m = '{10, 20, 30, 30};
        exp_p = '{-32768, 10, 20, 30};
        beat(4, bs[0], 128'h0);
        idx = 1;
        checks++; if (bus.vld_out !== 1'b1 || lane(bus.m_out, 0) !== 10) begin errors++; $display("FAIL stall_a: vld=%b m=%0d want 1 10", bus.vld_out, lane(bus.m_out, 0)); end
        stall_acc = 0;
        for (int c = 0; c < 5; c++) begin
            bus.rdy_in  = 1'b0;
            bus.vld_in  = 1'b1;
            bus.seq_len = 7'd4;
            bus.s_in    = bs[idx];
            bus.v_in    = 128'(idx);
            #1 acc = bus.rdy_out;
            @(posedge clock);
            @(negedge clock);
            if (acc) begin
                stall_acc++;
                idx++;
            end
            checks++; if (bus.vld_out !== 1'b1 || lane(bus.s_out, 0) !== 10 || lane(bus.m_out, 0) !== 10) begin errors++; $display("FAIL stall_frozen: cyc=%0d vld=%b s=%0d m=%0d want 1 10 10", c, bus.vld_out, lane(bus.s_out, 0), lane(bus.m_out, 0)); end
        end
        checks++; if (stall_acc !== EXP_EXTRA) begin errors++; $display("FAIL stall_accepts: got %0d want %0d", stall_acc, EXP_EXTRA); end
        oidx = 1;
        for (int c = 0; c < 12 && oidx < 4; c++) begin
            bus.rdy_in = 1'b1;
            bus.vld_in = (idx < 4);
            if (idx < 4) bus.s_in = bs[idx];
            #1 acc = bus.vld_in & bus.rdy_out;
            @(posedge clock);
            @(negedge clock);
            if (acc) idx++;
            if (bus.vld_out === 1'b1) begin
                checks++; if (lane(bus.s_out, 0) !== exp_s[oidx] || lane(bus.m_out, 0) !== exp_m[oidx] || lane(bus.m_prev_out, 0) !== exp_p[oidx]) begin errors++; $display("FAIL release_order: beat=%0d s=%0d m=%0d mp=%0d want %0d %0d %0d", oidx, lane(bus.s_out, 0), lane(bus.m_out, 0), lane(bus.m_prev_out, 0), exp_s[oidx], exp_m[oidx], exp_p[oidx]); end
                oidx++;
            end
        end
        bus.vld_in = 1'b0;
        checks++; if (oidx !== 4) begin errors++; $display("FAIL release_timeout: released %0d want 4", oidx); end
        checks++; if (bus.last_out !== 1'b1) begin errors++; $display("FAIL release_last: got %b want 1", bus.last_out); end
        idle();
        checks++; if (bus.vld_out !== 1'b0) begin errors++; $display("FAIL release_drain: vld=%b want 0", bus.vld_out); end
    endtask

    task automatic test_reset_mid_row;
        beat(4, pack4(3, 0, 0, 0), 128'h5);
        beat(4, pack4(8, 0, 0, 0), 128'h6);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.vld_out !== 1'b0 || bus.m_out !== 64'd0 || bus.m_prev_out !== 64'd0 || bus.s_out !== 64'd0 || bus.v_out !== 128'd0) begin errors++; $display("FAIL midrst_clear: vld=%b m=%h mp=%h s=%h want 0", bus.vld_out, bus.m_out, bus.m_prev_out, bus.s_out); end
        reset = 1'b0;
        #1;
        checks++; if (bus.rdy_out !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b want 1", bus.rdy_out); end
        beat(2, pack4(-5, 0, 0, 0), 128'h7);
        checks++; if (bus.first_out !== 1'b1 || bus.last_out !== 1'b0 || lane(bus.m_prev_out, 0) !== -32768 || lane(bus.m_out, 0) !== -5) begin errors++; $display("FAIL midrst_first: first/last=%b%b mp=%0d m=%0d want 10 -32768 -5", bus.first_out, bus.last_out, lane(bus.m_prev_out, 0), lane(bus.m_out, 0)); end
        beat(2, pack4(1, 0, 0, 0), 128'h8);
        checks++; if (bus.last_out !== 1'b1 || lane(bus.m_out, 0) !== 1) begin errors++; $display("FAIL midrst_close: last=%b m=%0d want 1 1", bus.last_out, lane(bus.m_out, 0)); end
    endtask

    task automatic test_max_seq;
        for (int i = 0; i < 64; i++) begin
            beat(0, pack4(i, 0, 0, 0), 128'(i));
            checks++; if (bus.last_out !== (i == 63) || bus.first_out !== (i == 0)) begin errors++; $display("FAIL maxseq_flags: beat=%0d first/last=%b%b want %b%b", i, bus.first_out, bus.last_out, (i == 0), (i == 63)); end
        end
        checks++; if (lane(bus.m_out, 0) !== 63) begin errors++; $display("FAIL maxseq_m: got %0d want 63", lane(bus.m_out, 0)); end
        beat(1, pack4(-7, 0, 0, 0), 128'h0);
        checks++; if (bus.first_out !== 1'b1 || bus.last_out !== 1'b1 || lane(bus.m_prev_out, 0) !== -32768) begin errors++; $display("FAIL maxseq_wrap: first/last=%b%b mp=%0d want 11 -32768", bus.first_out, bus.last_out, lane(bus.m_prev_out, 0)); end
    endtask

    initial begin
        reset       = 1'b1;
        bus.vld_in  = 1'b0;
        bus.rdy_in  = 1'b1;
        bus.seq_len = '0;
        bus.s_in    = '0;
        bus.v_in    = '0;
        test_reset();
        test_basic_row();
        test_negative_init();
        test_back_to_back();
        test_stall();
        test_reset_mid_row();
        test_max_seq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
